exec_ctrl: RTL and testbench
============================

EXEC_CTRL -- requirements
Module: exec_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32, giving the width of the stall counter.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  reset is asynchronous and active-low.
REQ-004 in_valid  in  1  decode stage presents an op.
REQ-005 in_ready  out  1  block accepts an op this cycle.
REQ-006 in_ctrl  in  5  ALU op code (common package enum).
REQ-007 in_a, in_b  in  64 each  source operands.
REQ-008 in_rd  in  5  destination register; in_wen  in  1  register write enable.
REQ-009 flush  in  1  kill any in-flight op (branch redirect).
REQ-010 alu_a, alu_b  out  64 each; alu_ctrl  out  5; alu_en  out  1  drive the ALU.
REQ-011 alu_result  in  64; alu_compl  in  1  ALU result and completion flag.
REQ-012 out_valid  out  1; out_ready  in  1  handshake to memory stage.
REQ-013 out_result  out  64; out_rd  out  5; out_wen  out  1  completed op.
REQ-014 stall_cnt  out  CNT_W  cycles spent waiting on the ALU.

Function
REQ-015 The block SHALL implement states IDLE, BUSY and DONE, held in a single state register.
REQ-016 in_ready SHALL be 1 when (state==IDLE or (state==DONE and out_ready==1)) and flush==0, else 0.
REQ-017 On accept (in_valid and in_ready): register in_ctrl/in_a/in_b/in_rd/in_wen; next state BUSY.
REQ-018 alu_a, alu_b, alu_ctrl SHALL be driven from the registered operands and SHALL remain stable throughout BUSY.
REQ-019 alu_en SHALL be 1 exactly in BUSY, 0 in IDLE and DONE, so it drops for at least one cycle between any two ops (restarts the multiplier/divider).
REQ-020 In BUSY with alu_compl==1: capture alu_result into out_result, copy rd/wen to out_rd/out_wen; next state DONE.
REQ-021 In BUSY with alu_compl==0: remain BUSY; stall_cnt increments by 1, saturating at all-ones (no wrap).
REQ-022 out_valid SHALL be 1 exactly in DONE; out_result/out_rd/out_wen SHALL hold stable while out_valid==1 and out_ready==0.
REQ-023 In DONE with out_ready==1: next state BUSY if a new op is accepted the same cycle, else IDLE.
REQ-024 Latency: single-cycle op accepted at cycle N -> out_valid at N+2; multi-cycle op -> out_valid the cycle after alu_compl==1.
REQ-025 Peak throughput: one op per 2 cycles (BUSY, DONE alternate under back-to-back accept).
REQ-026 flush==1 (any state) SHALL force next state IDLE and block acceptance; out_valid and alu_en are 0 from the next cycle; no result from the killed op is ever presented.
REQ-027 flush has priority over alu_compl and over the out handshake in the same cycle; stall_cnt still counts a BUSY/compl==0 flush cycle.
REQ-028 The block SHALL pass alu_result unmodified; division-by-zero and overflow semantics belong to the ALU.

Reset
REQ-029 reset==0 SHALL immediately force state IDLE, alu_en 0, out_valid 0, in_ready 0 while asserted, all data registers 0, stall_cnt 0.
REQ-030 Reset during BUSY SHALL abandon the op with no output; first accept is allowed the first cycle after reset deasserts.

Verification
REQ-031 ADD a=3 b=4 accepted cycle 0, alu_compl tied 1, out_ready=1 -> out_valid only in cycle 2, out_result=7, stall_cnt=0.
REQ-032 MUL a=6 b=7, alu_compl rises 5 cycles after alu_en -> alu_en high 6 cycles, out_result=42, stall_cnt=5.
REQ-033 DIVU a=10 b=0 result from ALU 0xFFFF_FFFF_FFFF_FFFF, out_ready low 3 cycles -> out_valid and data held 4 cycles, in_ready 0 until handshake.
REQ-034 Two ADDs back-to-back with out_ready=1 -> out_valid in cycles 2 and 4, alu_en low in cycle 2.
REQ-035 flush in 3rd BUSY cycle of DIV -> alu_en 0 and state IDLE next cycle, out_valid never asserts for it; next op completes normally.
REQ-036 reset pulsed low mid-BUSY with CNT_W=4 and stall_cnt saturated at 15 -> all outputs 0 immediately, stall_cnt=0.

Source files
------------

// File: rtl/exec_ctrl.sv
// Execute-stage controller: holds one decoded op, drives the ALU until it
// completes, then presents the result to the memory stage.
module exec_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_ctrl,
    input  logic [63:0]      in_a,
    input  logic [63:0]      in_b,
    input  logic [4:0]       in_rd,
    input  logic             in_wen,
    input  logic             flush,
    output logic [63:0]      alu_a,
    output logic [63:0]      alu_b,
    output logic [4:0]       alu_ctrl,
    output logic             alu_en,
    input  logic [63:0]      alu_result,
    input  logic             alu_compl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_result,
    output logic [4:0]       out_rd,
    output logic             out_wen,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic       accept;
    logic       complete;
    logic       stall;
    logic [4:0] op_rd;
    logic       op_wen;

    // Both ports use valid/ready: a transfer happens on a rising edge where
    // valid and ready are both 1; the producer holds its payload until then.
    always_comb begin
        in_ready = reset && !flush &&
                   ((state == S_IDLE) || ((state == S_DONE) && out_ready));
    end

    assign accept   = in_valid && in_ready;
    assign complete = (state == S_BUSY) && alu_compl && !flush;
    // A flushed wait cycle is still time spent waiting on the ALU.
    assign stall    = (state == S_BUSY) && !alu_compl;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (accept) state_nxt = S_BUSY;
                S_BUSY: if (alu_compl) state_nxt = S_DONE;
                S_DONE: if (out_ready) state_nxt = accept ? S_BUSY : S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // alu_en is low in DONE, so it always drops for a cycle between ops.
    always_comb begin
        alu_en    = (state == S_BUSY);
        out_valid = (state == S_DONE);
        dbg_state = state;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_ctrl <= '0;
            op_rd    <= '0;
            op_wen   <= 1'b0;
        end else if (accept) begin
            alu_a    <= in_a;
            alu_b    <= in_b;
            alu_ctrl <= in_ctrl;
            op_rd    <= in_rd;
            op_wen   <= in_wen;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_result <= '0;
            out_rd     <= '0;
            out_wen    <= 1'b0;
        end else if (complete) begin
            out_result <= alu_result;
            out_rd     <= op_rd;
            out_wen    <= op_wen;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_exec_ctrl.sv
// Bench for exec_ctrl: directed scenarios plus randomized traffic, all checked
// against a transaction-level model of the execute stage.
module tb_exec_ctrl;

    localparam int CW = 4;
    localparam int STALL_MAX = (1 << CW) - 1;
    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_MUL  = 5'd9;
    localparam logic [4:0] OP_DIV  = 5'd12;
    localparam logic [4:0] OP_DIVU = 5'd13;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, in_ready;
    logic [4:0]    in_ctrl;
    logic [63:0]   in_a, in_b;
    logic [4:0]    in_rd;
    logic          in_wen;
    logic          flush;
    logic [63:0]   alu_a, alu_b;
    logic [4:0]    alu_ctrl;
    logic          alu_en;
    logic [63:0]   alu_result;
    logic          alu_compl;
    logic          out_valid, out_ready;
    logic [63:0]   out_result;
    logic [4:0]    out_rd;
    logic          out_wen;
    logic [CW-1:0] stall_cnt;
    logic [1:0]    dbg_state;

    exec_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
        .in_a(in_a), .in_b(in_b), .in_rd(in_rd), .in_wen(in_wen),
        .flush(flush),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_en(alu_en),
        .alu_result(alu_result), .alu_compl(alu_compl),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .out_wen(out_wen),
        .stall_cnt(stall_cnt), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: an op is either waiting on the ALU (m_busy) or waiting for the
    // memory stage to take its result (m_done); never both.
    logic        m_busy, m_done;
    logic [63:0] m_a, m_b, m_res;
    logic [4:0]  m_ctrl, m_rd, m_ord;
    logic        m_wen, m_owen;
    int          m_stall;
    logic [63:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_busy = 0; m_done = 0;
        m_a = '0; m_b = '0; m_ctrl = '0; m_rd = '0; m_wen = 0;
        m_res = '0; m_ord = '0; m_owen = 0;
        m_stall = 0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b0; in_valid = 1'b1; flush = 1'b0; out_ready = 1'b1; alu_compl = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_alu_en", 64'(alu_en), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_alu_a", alu_a, 64'd0);
        check("rst_alu_b", alu_b, 64'd0);
        check("rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
        check("rst_out_result", out_result, 64'd0);
        check("rst_out_rd", 64'(out_rd), 64'd0);
        check("rst_out_wen", 64'(out_wen), 64'd0);
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        model_clear();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then
    // advance the model by the rules for the coming rising edge.
    task automatic step(input logic iv, input logic [4:0] ctl, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rd, input logic wn,
                        input logic ordy, input logic fl, input logic cmp,
                        input logic [63:0] res);
        logic        exp_rdy;
        logic [63:0] e;
        in_valid = iv; in_ctrl = ctl; in_a = a; in_b = b; in_rd = rd; in_wen = wn;
        out_ready = ordy; flush = fl; alu_compl = cmp; alu_result = res;
        #1;
        exp_rdy = !m_busy && (!m_done || ordy) && !fl;
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        check("alu_en", 64'(alu_en), 64'(m_busy));
        check("out_valid", 64'(out_valid), 64'(m_done));
        check("alu_a", alu_a, m_a);
        check("alu_b", alu_b, m_b);
        check("alu_ctrl", 64'(alu_ctrl), 64'(m_ctrl));
        check("out_result", out_result, m_res);
        check("out_rd", 64'(out_rd), 64'(m_ord));
        check("out_wen", 64'(out_wen), 64'(m_owen));
        check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
        if (m_busy && !cmp && m_stall < STALL_MAX) m_stall++;
        if (fl) begin
            m_busy = 0;
            m_done = 0;
            exp_q.delete();
        end else if (m_busy && cmp) begin
            m_busy = 0; m_done = 1;
            m_res = res; m_ord = m_rd; m_owen = m_wen;
            exp_q.push_back(res);
        end else if (m_done && ordy) begin
            m_done = 0;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("handshake", out_result, e);
            end
        end
        if (iv && exp_rdy) begin
            m_busy = 1;
            m_a = a; m_b = b; m_ctrl = ctl; m_rd = rd; m_wen = wn;
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy, input logic fl, input logic cmp, input logic [63:0] res);
        step(1'b0, 5'd0, 64'd0, 64'd0, 5'd0, 1'b0, ordy, fl, cmp, res);
    endtask

    initial begin
        reset = 1'b1; in_valid = 0; in_ctrl = '0; in_a = '0; in_b = '0; in_rd = '0;
        in_wen = 0; flush = 0; alu_result = '0; alu_compl = 0; out_ready = 0;
        #2;
        do_reset();

        // ADD with the ALU completing immediately
        step(1, OP_ADD, 64'd3, 64'd4, 5'd1, 1, 1, 0, 1, 64'd0);
        idle(1, 0, 1, 64'd7);
        check("add_out_valid", 64'(out_valid), 64'd1);
        check("add_result", out_result, 64'd7);
        check("add_stall", 64'(stall_cnt), 64'd0);
        idle(1, 0, 1, 64'd0);
        check("add_valid_drop", 64'(out_valid), 64'd0);

        // MUL completing five cycles after alu_en rises
        do_reset();
        step(1, OP_MUL, 64'd6, 64'd7, 5'd2, 1, 1, 0, 0, 64'd0);
        for (int i = 0; i < 5; i++) idle(1, 0, 0, 64'd0);
        idle(1, 0, 1, 64'd42);
        check("mul_result", out_result, 64'd42);
        check("mul_stall", 64'(stall_cnt), 64'd5);
        idle(1, 0, 0, 64'd0);

        // DIVU by zero, memory stage back-pressures for three cycles
        step(1, OP_DIVU, 64'd10, 64'd0, 5'd3, 1, 1, 0, 1, 64'd0);
        idle(1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
        for (int i = 0; i < 3; i++)
            step(1, OP_ADD, 64'd9, 64'd9, 5'd4, 1, 0, 0, 1, 64'd5);
        check("divu_held", out_result, 64'hFFFF_FFFF_FFFF_FFFF);
        idle(1, 0, 0, 64'd0);

        // back-to-back ADDs
        step(1, OP_ADD, 64'd1, 64'd2, 5'd5, 1, 1, 0, 1, 64'd0);
        idle(1, 0, 1, 64'd3);
        check("b2b_gap_alu_en", 64'(alu_en), 64'd0);
        step(1, OP_ADD, 64'd5, 64'd6, 5'd6, 0, 1, 0, 1, 64'd0);
        idle(1, 0, 1, 64'd11);
        check("b2b_second", out_result, 64'd11);
        idle(1, 0, 0, 64'd0);

        // flush in the third BUSY cycle of a DIV
        step(1, OP_DIV, 64'd100, 64'd7, 5'd7, 1, 1, 0, 0, 64'd0);
        idle(1, 0, 0, 64'd0);
        idle(1, 0, 0, 64'd0);
        idle(1, 1, 0, 64'd14);
        check("flush_alu_en", 64'(alu_en), 64'd0);
        idle(1, 0, 1, 64'd14);
        check("flush_no_valid", 64'(out_valid), 64'd0);
        step(1, OP_ADD, 64'd2, 64'd2, 5'd8, 1, 1, 0, 1, 64'd0);
        idle(1, 0, 1, 64'd4);
        check("after_flush", out_result, 64'd4);
        idle(1, 0, 0, 64'd0);

        // saturate the stall counter, then reset in the middle of BUSY
        do_reset();
        step(1, OP_MUL, 64'd3, 64'd3, 5'd9, 1, 1, 0, 0, 64'd0);
        for (int i = 0; i < 20; i++) idle(1, 0, 0, 64'd0);
        check("stall_sat", 64'(stall_cnt), 64'(STALL_MAX));
        do_reset();

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 9) < 6, 5'($urandom_range(0, 31)),
                     {$urandom, $urandom}, {$urandom, $urandom},
                     5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                     $urandom_range(0, 9) < 4, {$urandom, $urandom});
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
